// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared types and size helpers for the deserializer
// Contents:
//   deser_state_t      receive FSM state encoding
//   DESER_DEF_*        default frame geometry
//   deser_idx_w()      width of a counter that holds indices 0..n-1 plus headroom
//   deser_last_idx()   clamp value for a latched last-index field
package deser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } deser_state_t;

  localparam int DESER_DEF_DATA_WIDTH = 32;
  localparam int DESER_DEF_DATA_DEPTH = 4;
  localparam int DESER_DEF_DIV_WIDTH  = 8;

  function automatic int deser_idx_w(input int n);
    return $clog2(n) + 1;
  endfunction

  function automatic int deser_last_idx(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/deser_bit_sampler.sv
// rtl/deser_bit_sampler.sv - bit-period counter and mid-point sampler for the deserializer
// Build option: DESER_MAJORITY_EN adds a 3-sample majority vote when clk_div >= 3.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   start          frame edge cycle: restart the bit period
//   run            advance the bit period this cycle
//   clk_div        latched bit period in cycles (never 0)
//   serial_in      raw serial line
//   bit_tick       last cycle of the current bit period
//   sample_valid   sample_bit carries the decided value of the current bit
//   sample_bit     decided bit value
module deser_bit_sampler
  import deser_pkg::*;
#(
  parameter int DIV_WIDTH = DESER_DEF_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] clk_div,
  input  logic                 serial_in,
  output logic                 bit_tick,
  output logic                 sample_valid,
  output logic                 sample_bit
);

  logic [DIV_WIDTH-1:0] clk_cnt;
  logic [DIV_WIDTH-1:0] mid;
  // The line is viewed one cycle late so that the edge cycle (handled in IDLE)
  // is processed as count 0 of bit 0 in the first RECEIVE cycle.
  logic                 din_q;

  assign mid      = clk_div >> 1;
  assign bit_tick = run && (clk_cnt == clk_div - DIV_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      din_q   <= 1'b0;
    end else begin
      din_q <= serial_in;
      if (start) begin
        clk_cnt <= '0;
      end else if (run) begin
        clk_cnt <= bit_tick ? '0 : clk_cnt + DIV_WIDTH'(1);
      end
    end
  end

`ifdef DESER_MAJORITY_EN
  logic din_q2;
  logic din_q3;
  logic vote_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q2 <= 1'b0;
      din_q3 <= 1'b0;
    end else begin
      din_q2 <= din_q;
      din_q3 <= din_q2;
    end
  end

  assign vote_en = (clk_div >= DIV_WIDTH'(3));

  // When the count reaches mid+1 the three delay taps hold mid+1, mid, mid-1.
  always_comb begin
    sample_valid = run && (clk_cnt == mid);
    sample_bit   = din_q;
    if (vote_en) begin
      sample_valid = run && (clk_cnt == mid + DIV_WIDTH'(1));
      sample_bit   = (din_q & din_q2) | (din_q & din_q3) | (din_q2 & din_q3);
    end
  end
`else
  assign sample_valid = run && (clk_cnt == mid);
  assign sample_bit   = din_q;
`endif

endmodule

// File: rtl/deserializer.sv
// rtl/deserializer.sv - framed serial-to-parallel receiver with done/abort reporting
// Build option: DESER_MAJORITY_EN (see deser_bit_sampler).
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   serial_in            serial data, one bit per clk_div cycles, LSB first
//   serial_en            frame-active qualifier; rising edge starts a frame
//   clk_div/width/depth  bit period, last bit index, last sample index
//   par_out              last completed frame, par_out[sample][bit]
//   done                 one-cycle pulse when par_out updates
//   busy                 frame reception in progress
//   frame_err            one-cycle pulse when a frame is aborted
//   bit_count            current bit index
//   sample_count         current sample index
module deserializer
  import deser_pkg::*;
#(
  parameter int DATA_WIDTH = DESER_DEF_DATA_WIDTH,
  parameter int DATA_DEPTH = DESER_DEF_DATA_DEPTH,
  parameter int DIV_WIDTH  = DESER_DEF_DIV_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 serial_in,
  input  logic                                 serial_en,
  input  logic [DIV_WIDTH-1:0]                 clk_div,
  input  logic [$clog2(DATA_WIDTH):0]          width,
  input  logic [$clog2(DATA_DEPTH):0]          depth,
  output logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] par_out,
  output logic                                 done,
  output logic                                 busy,
  output logic                                 frame_err,
  output logic [$clog2(DATA_WIDTH):0]          bit_count,
  output logic [$clog2(DATA_DEPTH):0]          sample_count
);

  localparam int BW   = deser_idx_w(DATA_WIDTH);
  localparam int SW   = deser_idx_w(DATA_DEPTH);
  localparam int BSEL = $clog2(DATA_WIDTH);
  localparam int SSEL = $clog2(DATA_DEPTH);
  localparam logic [BW-1:0] W_MAX = BW'(deser_last_idx(DATA_WIDTH));
  localparam logic [SW-1:0] D_MAX = SW'(deser_last_idx(DATA_DEPTH));

  deser_state_t                          state;
  logic                                  en_q;
  logic [DIV_WIDTH-1:0]                  clk_div_r;
  logic [BW-1:0]                         width_r;
  logic [SW-1:0]                         depth_r;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] stage;
  logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] stage_next;
  logic                                  start;
  logic                                  run;
  logic                                  bit_tick;
  logic                                  sample_valid;
  logic                                  sample_bit;

  // DONE also accepts a fresh edge, so one idle cycle between frames suffices.
  assign start = serial_en && !en_q && (state != RECEIVE);
  // en_q lines up with the delayed line view used by the sampler.
  assign run   = (state == RECEIVE) && en_q;

  deser_bit_sampler #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_sampler (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .run          (run),
    .clk_div      (clk_div_r),
    .serial_in    (serial_in),
    .bit_tick     (bit_tick),
    .sample_valid (sample_valid),
    .sample_bit   (sample_bit)
  );

  // Next staging contents; par_out loads from here so a bit sampled on the
  // final tick (clk_div of 1 or 2) is included.
  always_comb begin
    stage_next = start ? '0 : stage;
    if (sample_valid) begin
      stage_next[sample_count[SSEL-1:0]][bit_count[BSEL-1:0]] = sample_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      en_q         <= 1'b0;
      clk_div_r    <= '0;
      width_r      <= '0;
      depth_r      <= '0;
      stage        <= '0;
      par_out      <= '0;
      done         <= 1'b0;
      busy         <= 1'b0;
      frame_err    <= 1'b0;
      bit_count    <= '0;
      sample_count <= '0;
    end else begin
      en_q      <= serial_en;
      done      <= 1'b0;
      frame_err <= 1'b0;
      stage     <= stage_next;
      case (state)
        RECEIVE: begin
          if (!en_q) begin
            state        <= IDLE;
            frame_err    <= 1'b1;
            busy         <= 1'b0;
            bit_count    <= '0;
            sample_count <= '0;
          end else if (bit_tick) begin
            if (bit_count == width_r) begin
              bit_count <= '0;
              if (sample_count == depth_r) begin
                state        <= DONE;
                done         <= 1'b1;
                busy         <= 1'b0;
                par_out      <= stage_next;
                sample_count <= '0;
              end else begin
                sample_count <= sample_count + SW'(1);
              end
            end else begin
              bit_count <= bit_count + BW'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          if (start) begin
            state        <= RECEIVE;
            busy         <= 1'b1;
            clk_div_r    <= (clk_div == '0) ? DIV_WIDTH'(1) : clk_div;
            width_r      <= (width > W_MAX) ? W_MAX : width;
            depth_r      <= (depth > D_MAX) ? D_MAX : depth;
            bit_count    <= '0;
            sample_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// tb/tb_deserializer.sv - scoreboard bench for the deserializer
`timescale 1ns/1ps
module tb_deserializer;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              serial_in;
  logic              serial_en;
  logic [7:0]        clk_div;
  logic [5:0]        width;
  logic [2:0]        depth;
  logic [3:0][31:0]  par_out;
  logic              done;
  logic              busy;
  logic              frame_err;
  logic [5:0]        bit_count;
  logic [2:0]        sample_count;

  always #5 clk = ~clk;

  deserializer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .serial_en    (serial_en),
    .clk_div      (clk_div),
    .width        (width),
    .depth        (depth),
    .par_out      (par_out),
    .done         (done),
    .busy         (busy),
    .frame_err    (frame_err),
    .bit_count    (bit_count),
    .sample_count (sample_count)
  );

  typedef struct {
    bit               err;
    logic [3:0][31:0] data;
    int               cyc;
  } ev_t;

  ev_t              sbq[$];
  ev_t              e;
  int               cyc = 0;
  int               checks = 0;
  int               errors = 0;
  logic [3:0][31:0] last_good = '0;
  logic [3:0][31:0] exp;
  logic [3:0][31:0] din;
  bit               busy_prev = 1'b0;
  bit               chk_busy_next = 1'b0;
  int               t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Transmitter model plus scoreboard push. div/w/d are the effective values the
  // receiver should latch from the raw clk_div/width/depth driven at the edge.
  task automatic send_frame(input logic [3:0][31:0] data, input logic [3:0][31:0] expd,
                            input logic [7:0] div_raw, input logic [5:0] w_raw,
                            input logic [2:0] d_raw, input int div, input int w, input int d,
                            input int hold, input int abort_at, input int rst_at,
                            input bit glitch, output int start_cyc);
    ev_t ev;
    int  k;
    k = 0;
    @(posedge clk); #1;
    start_cyc = cyc;
    serial_en = 1'b1;
    clk_div   = div_raw;
    width     = w_raw;
    depth     = d_raw;
    if (abort_at >= 0) begin
      ev.err = 1'b1; ev.data = last_good; ev.cyc = start_cyc + abort_at + 2;
      sbq.push_back(ev);
    end else if (rst_at < 0) begin
      ev.err = 1'b0; ev.data = expd; ev.cyc = start_cyc + (w + 1) * (d + 1) * div + 1;
      sbq.push_back(ev);
      last_good = expd;
    end
    for (int s = 0; s <= d; s++) begin
      for (int b = 0; b <= w; b++) begin
        for (int c = 0; c < div; c++) begin
          if (k == abort_at) begin
            serial_en = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            return;
          end
          if (k == rst_at) begin
            rst_n     = 1'b0;
            serial_en = 1'b0;
            @(posedge clk); #1;
            rst_n     = 1'b1;
            last_good = '0;
            return;
          end
          serial_in = data[s][b] ^ (glitch && (c == div / 2));
          @(posedge clk); #1;
          if (k == 0) begin
            clk_div = 8'd3;
            width   = 6'd1;
            depth   = 3'd0;
          end
          k++;
        end
      end
    end
    repeat (hold) begin @(posedge clk); #1; end
    serial_en = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_busy_next) begin
      chk("busy_after_abort", busy, 1'b0);
      chk_busy_next = 1'b0;
    end
    if (done || frame_err) begin
      chk("done_and_err_exclusive", done && frame_err, 1'b0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b frame_err=%0b at cycle %0d", done, frame_err, cyc);
      end else begin
        e = sbq.pop_front();
        chk("evt_kind", frame_err, e.err);
        chk("evt_par_out", par_out, e.data);
        chk("evt_cycle", cyc, e.cyc);
        if (done) begin
          chk("busy_at_done", busy, 1'b0);
          chk("busy_before_done", busy_prev, 1'b1);
        end
      end
      if (frame_err) chk_busy_next = 1'b1;
    end
    busy_prev = busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; serial_in = 1'b0; serial_en = 1'b0;
    clk_div = '0; width = '0; depth = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_par_out", par_out, 128'h0);
    chk("reset_done", done, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_frame_err", frame_err, 1'b0);
    chk("reset_bit_count", bit_count, 6'd0);
    chk("reset_sample_count", sample_count, 3'd0);

    // Loopback, default size: done 4*128+1 = 513 cycles after the edge
    din = {32'hFFFF0000, 32'hA5A5A5A5, 32'h01234567, 32'hDEADBEEF};
    send_frame(din, din, 8'd4, 6'd31, 3'd3, 4, 31, 3, 0, -1, -1, 1'b0, t0);

    // Reduced frame, one idle cycle after the previous one: done at +17
    din = {32'h77777777, 32'h66666666, 32'hFFFFFF5A, 32'hFFFFFFC3};
    exp = {32'h0, 32'h0, 32'h0000005A, 32'h000000C3};
    send_frame(din, exp, 8'd1, 6'd7, 3'd1, 1, 7, 1, 0, -1, -1, 1'b0, t0);

    // Trailing enable held 3 cycles: exactly one done, re-arm only after a fall
    din = {32'h0, 32'h0, 32'h0, 32'h000000A7};
    send_frame(din, din, 8'd2, 6'd7, 3'd0, 2, 7, 0, 3, -1, -1, 1'b0, t0);

    // Abort at bit 10 of sample 1 (data cycle (32+10)*2 = 84): par_out keeps 0xA7 frame
    din = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    send_frame(din, din, 8'd2, 6'd31, 3'd3, 2, 31, 3, 0, 84, -1, 1'b0, t0);

    // Clean frame after the abort: 16-bit samples, three of them
    din = {32'h55555555, 32'h80008000, 32'hFFFF0001, 32'h1234CAFE};
    exp = {32'h0, 32'h00008000, 32'h00000001, 32'h0000CAFE};
    send_frame(din, exp, 8'd3, 6'd15, 3'd2, 3, 15, 2, 0, -1, -1, 1'b0, t0);

    // Mid-cycle glitch on every bit, clk_div=8
    din = {32'h0, 32'h0, 32'h0000003C, 32'h00000096};
`ifdef DESER_MAJORITY_EN
    exp = {32'h0, 32'h0, 32'h0000003C, 32'h00000096};
`else
    exp = {32'h0, 32'h0, 32'h000000C3, 32'h00000069};
`endif
    send_frame(din, exp, 8'd8, 6'd7, 3'd1, 8, 7, 1, 0, -1, -1, 1'b1, t0);

    // Out-of-range config: clk_div 0 -> 1, width 45 -> 31, depth 6 -> 3; done at +129
    din = {32'h80000001, 32'h0F0F0F0F, 32'h9ABCDEF0, 32'h12345678};
    send_frame(din, din, 8'd0, 6'd45, 3'd6, 1, 31, 3, 0, -1, -1, 1'b0, t0);

    // Reset for one cycle during sample 2 (data cycle 70): everything back to 0, no done
    din = {32'hCAFEBABE, 32'hFEEDFACE, 32'h0BADF00D, 32'h13579BDF};
    send_frame(din, din, 8'd1, 6'd31, 3'd3, 1, 31, 3, 0, -1, 70, 1'b0, t0);
    chk("rst_mid_par_out", par_out, 128'h0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_done", done, 1'b0);
    chk("rst_mid_bit_count", bit_count, 6'd0);
    chk("rst_mid_sample_count", sample_count, 3'd0);

    // Clean frame after reset: 12-bit samples, clk_div=5, done at +241
    din = {32'hAAAAA555, 32'h00000FFF, 32'h12345123, 32'hFFFFFABC};
    exp = {32'h00000555, 32'h00000FFF, 32'h00000123, 32'h00000ABC};
    send_frame(din, exp, 8'd5, 6'd11, 3'd3, 5, 11, 3, 0, -1, -1, 1'b0, t0);

    for (int i = 0; i < 3000 && sbq.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
